// File: rtl/reg_file_2r1w_pkg.sv
// reg_pkg: shared register-file constants, data type and address sizing helper.
// No ports; imported by the interface, the read port and the top level.
package reg_pkg;

  localparam int DATA_W       = 8;
  localparam int NREGS        = 8;
  localparam int NREGS_ADDR_W = 3;

  typedef logic [DATA_W-1:0] data_t;

  // Address width for n words, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// reg_file_if: write port, two read ports and sticky error of the register file.
// master = decoder/ALU side (drives we/addr/data/re), slave = register file.
interface reg_file_if
  import reg_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int ADDR_W = NREGS_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  dout_a;
  logic              vld_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  dout_b;
  logic              vld_b;
  logic              err;

  modport master (
    output we, waddr, wdata,
    output re_a, raddr_a, re_b, raddr_b,
    input  dout_a, vld_a, dout_b, vld_b, err
  );

  modport slave (
    input  we, waddr, wdata,
    input  re_a, raddr_a, re_b, raddr_b,
    output dout_a, vld_a, dout_b, vld_b, err
  );

endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// reg_read_port: one registered read port with range check and write bypass.
// Ports: clk/rst, i_re/i_raddr, i_rdata (array word), i_we/i_waddr/i_wdata, o_dout/o_vld/o_err_req.
module reg_read_port
  import reg_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int DEPTH  = NREGS,
  parameter int ADDR_W = NREGS_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [WIDTH-1:0]  i_rdata,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_dout,
  output logic              o_vld,
  output logic              o_err_req
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] w_dnext;
  logic [WIDTH-1:0] r_dout;
  logic             r_vld;

  assign w_in_range = ({1'b0, i_raddr} < LP_DEPTH);

  // i_we is already range-qualified, so a hit implies an in-range read.
  assign w_hit = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

  always_comb begin
    w_dnext = i_rdata;
    unique case (1'b1)
      !w_in_range: w_dnext = '0;
      w_hit:       w_dnext = i_wdata;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= i_re;
      if (i_re) r_dout <= w_dnext;
    end
  end

  assign o_dout    = r_dout;
  assign o_vld     = r_vld;
  assign o_err_req = i_re && !w_in_range;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: DEPTH x WIDTH register file, one write port, two registered read ports.
// Ports: clk, rst (sync, active-high), bus (reg_file_if.slave: we/waddr/wdata, re/raddr/dout/vld x2, err).
module reg_file_2r1w
  import reg_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int DEPTH  = NREGS,
  parameter int ADDR_W = clog2_min1(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_err;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;
  logic [WIDTH-1:0] w_dout_a;
  logic [WIDTH-1:0] w_dout_b;
  logic             w_vld_a;
  logic             w_vld_b;
  logic             w_err_a;
  logic             w_err_b;

  assign w_wr_ok = bus.we && ({1'b0, bus.waddr} < LP_DEPTH);

  // Explicit compare loop keeps DEPTH free of power-of-two constraints.
  always_comb begin
    w_rdata_a = '0;
    w_rdata_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == ADDR_W'(i)) w_rdata_a = r_mem[i];
      if (bus.raddr_b == ADDR_W'(i)) w_rdata_b = r_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && bus.waddr == ADDR_W'(i)) r_mem[i] <= bus.wdata;
      end
      if (w_err_a || w_err_b || (bus.we && !w_wr_ok)) r_err <= 1'b1;
    end
  end

  reg_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_port_a (
    .clk(clk), .rst(rst),
    .i_re(bus.re_a), .i_raddr(bus.raddr_a), .i_rdata(w_rdata_a),
    .i_we(w_wr_ok), .i_waddr(bus.waddr), .i_wdata(bus.wdata),
    .o_dout(w_dout_a), .o_vld(w_vld_a), .o_err_req(w_err_a)
  );

  reg_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_port_b (
    .clk(clk), .rst(rst),
    .i_re(bus.re_b), .i_raddr(bus.raddr_b), .i_rdata(w_rdata_b),
    .i_we(w_wr_ok), .i_waddr(bus.waddr), .i_wdata(bus.wdata),
    .o_dout(w_dout_b), .o_vld(w_vld_b), .o_err_req(w_err_b)
  );

  assign bus.dout_a = w_dout_a;
  assign bus.vld_a  = w_vld_a;
  assign bus.dout_b = w_dout_b;
  assign bus.vld_b  = w_vld_b;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed + scoreboard bench for two register-file builds.
// dut A: DEPTH=8 BYPASS=1; dut B: DEPTH=6 BYPASS=0; both see identical stimulus.
module tb_reg_file_2r1w;
  import reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  reg_file_if #(.WIDTH(8), .ADDR_W(3)) bus_a ();
  reg_file_if #(.WIDTH(8), .ADDR_W(3)) bus_b ();

  assign bus_b.we      = bus_a.we;
  assign bus_b.waddr   = bus_a.waddr;
  assign bus_b.wdata   = bus_a.wdata;
  assign bus_b.re_a    = bus_a.re_a;
  assign bus_b.raddr_a = bus_a.raddr_a;
  assign bus_b.re_b    = bus_a.re_b;
  assign bus_b.raddr_b = bus_a.raddr_b;

  reg_file_2r1w #(
    .WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1)
  ) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  reg_file_2r1w #(
    .WIDTH(8), .DEPTH(6), .ADDR_W(3), .BYPASS(0)
  ) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check(string tag, data_t got, data_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit we, logic [2:0] wa, data_t wd,
                       bit rea, logic [2:0] ra,
                       bit reb, logic [2:0] rb);
    bus_a.we      = we;
    bus_a.waddr   = wa;
    bus_a.wdata   = wd;
    bus_a.re_a    = rea;
    bus_a.raddr_a = ra;
    bus_a.re_b    = reb;
    bus_a.raddr_b = rb;
  endtask

  task automatic exp_a(string t, data_t da, bit va,
                       data_t db, bit vb, bit e);
    check({t, "/A.dout_a"}, bus_a.dout_a, da);
    check({t, "/A.vld_a"}, 8'(bus_a.vld_a), 8'(va));
    check({t, "/A.dout_b"}, bus_a.dout_b, db);
    check({t, "/A.vld_b"}, 8'(bus_a.vld_b), 8'(vb));
    check({t, "/A.err"}, 8'(bus_a.err), 8'(e));
  endtask

  task automatic exp_b(string t, data_t da, bit va,
                       data_t db, bit vb, bit e);
    check({t, "/B.dout_a"}, bus_b.dout_a, da);
    check({t, "/B.vld_a"}, 8'(bus_b.vld_a), 8'(va));
    check({t, "/B.dout_b"}, bus_b.dout_b, db);
    check({t, "/B.vld_b"}, 8'(bus_b.vld_b), 8'(vb));
    check({t, "/B.err"}, 8'(bus_b.err), 8'(e));
  endtask

  data_t      m_a [8];
  data_t      m_b [8];
  bit         e_b;
  logic [2:0] wa, ra, rb;
  data_t      wd, ea_a, eb_a, ea_b, eb_b;

  initial begin
    // reset holds off a concurrent write
    rst = 1'b1;
    drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    step();
    exp_a("rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_b("rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0);
    step();
    exp_a("rst_rd", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    exp_b("rst_rd", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

    // write then read; addr 7 is out of range for B
    drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    drive(1'b1, 3'd7, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd7);
    step();
    exp_a("wr_rd", 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0);
    exp_b("wr_rd", 8'hA5, 1'b1, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 1'b0, 3'd7);
    step();
    exp_a("hold", 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0);
    exp_b("hold", 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1);

    // same-cycle collision on addr 2
    drive(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    drive(1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 1'b1, 3'd2);
    step();
    exp_a("coll", 8'h22, 1'b1, 8'h22, 1'b1, 1'b0);
    exp_b("coll", 8'h11, 1'b1, 8'h11, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2);
    step();
    exp_a("coll_nx", 8'h22, 1'b1, 8'h22, 1'b1, 1'b0);
    exp_b("coll_nx", 8'h22, 1'b1, 8'h22, 1'b1, 1'b1);

    // out of range on B (DEPTH=6)
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    rst = 1'b0;
    exp_a("rst2", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_b("rst2", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 3'd6, 8'h55, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    exp_a("oor_wr", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_b("oor_wr", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0);
    step();
    exp_a("oor_rd", 8'h55, 1'b1, 8'h00, 1'b0, 1'b0);
    exp_b("oor_rd", 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    repeat (10) step();
    exp_a("oor_idle", 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_b("oor_idle", 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(5 - i));
      step();
      check("oor_keep/B.dout_a", bus_b.dout_a, 8'h00);
      check("oor_keep/B.dout_b", bus_b.dout_b, 8'h00);
    end
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    rst = 1'b0;
    exp_b("oor_clr", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // reset in the middle of a read/write stream
    drive(1'b1, 3'd1, 8'h77, 1'b1, 3'd1, 1'b0, 3'd0);
    step();
    exp_a("ms1", 8'h77, 1'b1, 8'h00, 1'b0, 1'b0);
    exp_b("ms1", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 1'b0, 3'd0);
    step();
    exp_a("ms_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_b("ms_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd1);
    step();
    exp_a("ms_nx", 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    exp_b("ms_nx", 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // throughput: write + two reads every cycle against a model
    for (int i = 0; i < 8; i++) begin
      m_a[i] = 8'h00;
      m_b[i] = 8'h00;
    end
    e_b = 1'b0;
    for (int c = 0; c < 16; c++) begin
      wa = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      ea_a = (wa == ra) ? wd : m_a[ra];
      eb_a = (wa == rb) ? wd : m_a[rb];
      ea_b = (ra >= 3'd6) ? 8'h00 : m_b[ra];
      eb_b = (rb >= 3'd6) ? 8'h00 : m_b[rb];
      if (wa >= 3'd6 || ra >= 3'd6 || rb >= 3'd6) e_b = 1'b1;
      m_a[wa] = wd;
      if (wa < 3'd6) m_b[wa] = wd;
      drive(1'b1, wa, wd, 1'b1, ra, 1'b1, rb);
      step();
      exp_a("thru", ea_a, 1'b1, eb_a, 1'b1, 1'b0);
      exp_b("thru", ea_b, 1'b1, eb_b, 1'b1, e_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
